// File: rtl/grant_d_receiver_pkg.sv
// Shared definitions for the TileLink D-channel receiver: opcodes, opcode
// classifiers and the receive FSM state encoding.
package grant_d_receiver_pkg;

    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] OP_GRANT           = 3'd4;
    localparam logic [2:0] OP_GRANT_DATA      = 3'd5;
    localparam logic [2:0] OP_RELEASE_ACK     = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESP    = 2'd2
    } rx_state_e;

    function automatic logic is_data(input logic [2:0] opcode);
        return (opcode == OP_ACCESS_ACK_DATA) || (opcode == OP_GRANT_DATA);
    endfunction

    function automatic logic needs_ack(input logic [2:0] opcode);
        return (opcode == OP_GRANT) || (opcode == OP_GRANT_DATA);
    endfunction

    function automatic logic is_legal(input logic [2:0] opcode);
        return (opcode == OP_ACCESS_ACK) || (opcode == OP_ACCESS_ACK_DATA) ||
               (opcode == OP_GRANT) || (opcode == OP_GRANT_DATA) ||
               (opcode == OP_RELEASE_ACK);
    endfunction

endpackage

// File: rtl/grant_ack_queue.sv
// Small FIFO holding sink ids awaiting a GrantAck on the E channel.
module grant_ack_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a full queue may still accept.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        end
    end

endmodule

// File: rtl/grant_d_receiver.sv
// TileLink D-channel client receiver: assembles multi-beat responses and
// queues a GrantAck for every Grant/GrantData.
module grant_d_receiver
    import grant_d_receiver_pkg::*;
#(
    parameter int unsigned SOURCE_W  = 6,
    parameter int unsigned SINK_W    = 4,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned BEATS     = 2,
    parameter int unsigned ACK_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      d_valid,
    output logic                      d_ready,
    input  logic [2:0]                d_opcode,
    input  logic [2:0]                d_param,
    input  logic [2:0]                d_size,
    input  logic [SOURCE_W-1:0]       d_source,
    input  logic [SINK_W-1:0]         d_sink,
    input  logic                      d_denied,
    input  logic                      d_corrupt,
    input  logic [DATA_W-1:0]         d_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [2:0]                resp_opcode,
    output logic [2:0]                resp_param,
    output logic [SOURCE_W-1:0]       resp_source,
    output logic                      resp_denied,
    output logic                      resp_corrupt,
    output logic [BEATS*DATA_W-1:0]   resp_data,
    output logic                      e_valid,
    input  logic                      e_ready,
    output logic [SINK_W-1:0]         e_sink,
    output logic                      err_illegal
);
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BLOCK_LG = $clog2(BEATS * DATA_W / 8);

    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [SINK_W-1:0] sink_q;

    logic              beat_legal_c;
    logic              beat_last_c;
    logic              beat_grant_c;
    logic              fire_c;
    logic [2:0]        eff_op_c;
    logic [SINK_W-1:0] eff_sink_c;
    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;

    // Beat classification; header fields come from the first beat only.
    always_comb begin
        eff_op_c     = (state == ST_IDLE) ? d_opcode : resp_opcode;
        eff_sink_c   = (state == ST_IDLE) ? d_sink : sink_q;
        beat_legal_c = (state != ST_IDLE) || is_legal(d_opcode);
        beat_last_c  = 1'b1;
        if (state == ST_COLLECT)
            beat_last_c = (cnt == CNT_W'(BEATS - 1));
        else if (is_data(d_opcode) && (BEATS > 1) && (d_size >= 3'(BLOCK_LG)))
            beat_last_c = 1'b0;
        beat_grant_c = beat_legal_c && needs_ack(eff_op_c) && beat_last_c;
        d_ready      = (state != ST_RESP) && !(beat_grant_c && q_full && !e_ready);
        fire_c       = d_valid && d_ready;
        q_push       = fire_c && beat_grant_c;
    end

    assign e_valid = !q_empty;
    assign q_pop   = e_valid && e_ready;

    grant_ack_queue #(
        .DEPTH (ACK_DEPTH),
        .WIDTH (SINK_W)
    ) u_ack_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (q_push),
        .push_data (eff_sink_c),
        .pop       (q_pop),
        .pop_data  (e_sink),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sink_q       <= '0;
            resp_valid   <= 1'b0;
            resp_opcode  <= '0;
            resp_param   <= '0;
            resp_source  <= '0;
            resp_denied  <= 1'b0;
            resp_corrupt <= 1'b0;
            resp_data    <= '0;
            err_illegal  <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire_c) begin
                        if (!beat_legal_c) begin
                            err_illegal <= 1'b1;
                        end else begin
                            resp_opcode           <= d_opcode;
                            resp_param            <= d_param;
                            resp_source           <= d_source;
                            resp_denied           <= d_denied;
                            resp_corrupt          <= d_corrupt;
                            sink_q                <= d_sink;
                            resp_data[0 +: DATA_W] <= d_data;
                            if (beat_last_c) begin
                                state      <= ST_RESP;
                                resp_valid <= 1'b1;
                            end else begin
                                state <= ST_COLLECT;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                end
                ST_COLLECT: begin
                    if (fire_c) begin
                        resp_data[32'(cnt) * DATA_W +: DATA_W] <= d_data;
                        resp_denied  <= resp_denied | d_denied;
                        resp_corrupt <= resp_corrupt | d_corrupt;
                        if (beat_last_c) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= CNT_W'(cnt + CNT_W'(1));
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
